// File: rtl/multi_tone_pkg.sv
// multi_tone_pkg: shared types and helpers for the multi-tone DDS DAC driver.
//   quadrant_t        - sine quadrant taken from the top two phase bits
//   LFSR_POLY/SEED    - Galois LFSR x^16+x^14+x^13+x^11+1 (right-shifting form)
//   saturate()        - clamp a signed value into a signed w-bit range
//   to_offset_binary()- two's complement -> offset binary (invert bit w-1)
//   lfsr_next()       - one step of the dither LFSR
package multi_tone_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quadrant_t;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  // Only the low w bits of the result are meaningful.
  function automatic logic [31:0] to_offset_binary(input logic signed [31:0] v, input int w);
    return v ^ (32'd1 << (w - 1));
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/multi_tone_dac_driver_lut.sv
// sine_quarter_lut: quarter-wave sine ROM with one registered read port per
// channel (replicated read logic over one shared table).
//   clk  - sample clock
//   en   - read registers load only when set (pipeline hold otherwise)
//   addr - N_RD packed addresses, LUT_AW+1 bits each (0 .. 2^LUT_AW)
//   data - N_RD packed signed samples, SIN_W bits each, one cycle after addr
// Entry k = round((2^(SIN_W-1)-1) * sin(pi*k / 2^(LUT_AW+1))), k = 0..2^LUT_AW.
module sine_quarter_lut #(
  parameter int N_RD   = 2,
  parameter int LUT_AW = 10,
  parameter int SIN_W  = 14
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [N_RD*(LUT_AW+1)-1:0]    addr,
  output logic [N_RD*SIN_W-1:0]         data
);

  localparam int AW    = LUT_AW + 1;
  localparam int DEPTH = (1 << LUT_AW) + 1;

  function automatic logic [SIN_W-1:0] sine_entry(input int k);
    real amp;
    real x;
    amp = real'((1 << (SIN_W - 1)) - 1);
    x   = amp * $sin(3.14159265358979323846 * real'(k) / real'(2 << LUT_AW));
    return SIN_W'($rtoi(x + 0.5));
  endfunction

  logic [SIN_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = sine_entry(k);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < N_RD; i++) begin
        data[i*SIN_W +: SIN_W] <= rom[addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/multi_tone_dac_driver.sv
// multi_tone_dac_driver: N-channel DDS tone generator and saturating combiner
// driving a dual-port offset-binary DAC.
//   clk, reset         - sample clock, synchronous active-high reset
//   en                 - advance accumulators and pipeline
//   sync_clr           - zero all accumulators and flush pipeline valid bits
//   cfg_we/ch/inc/shift- per-channel phase increment and attenuation write
//   ovf_clr            - clear sticky overflow flag
//   dac_a, dac_b       - offset-binary samples (B: sum, or channel 0 alone)
//   dac_valid          - outputs updated this cycle
//   ovf                - sticky saturation flag
// Optional build macro TONE_DITHER_EN: LFSR dither added into the phase bits
// below the LUT address before S2 (accumulators unaffected, same latency).
// Pipeline: acc (S1) -> quadrant/address (S2) -> LUT read, negate, shift (S3)
//           -> sum (S4) -> saturate/format/output (S5). 4 en-cycles acc->dac.
module multi_tone_dac_driver
  import multi_tone_pkg::*;
#(
  parameter int  N_CH       = 2,
  parameter int  PHASE_W    = 32,
  parameter int  LUT_AW     = 10,
  parameter int  SIN_W      = 14,
  parameter int  DAC_W      = 14,
  parameter int  OUT_B_MODE = 0,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync_clr,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [2:0]         cfg_shift,
  input  logic               ovf_clr,
  output logic [DAC_W-1:0]   dac_a,
  output logic [DAC_W-1:0]   dac_b,
  output logic               dac_valid,
  output logic               ovf
);

  localparam int AW     = LUT_AW + 1;
  localparam int HI_W   = LUT_AW + 2;
  localparam int SUM_W  = SIN_W + $clog2(N_CH) + 1;
  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

  logic [PHASE_W-1:0]      inc_r     [N_CH];
  logic [PHASE_W-1:0]      acc_r     [N_CH];
  logic [2:0]              shift_r   [N_CH];
  logic [HI_W-1:0]         phase_top [N_CH];
  logic [N_CH*AW-1:0]      addr_c;
  logic [N_CH*AW-1:0]      addr_s2;
  quadrant_t               q_s2      [N_CH];
  quadrant_t               q_s3      [N_CH];
  logic [N_CH*SIN_W-1:0]   lut_q;
  logic signed [SIN_W-1:0] lut_s     [N_CH];
  logic signed [SIN_W-1:0] tone_s3   [N_CH];
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] sum_s4;
  logic signed [SUM_W-1:0] b_src;
  logic signed [31:0]      sat_a;
  logic signed [31:0]      sat_b;
  logic                    clamp_a;
  logic                    clamp_b;
  logic                    v_s2, v_s3, v_s4;

  // Config and accumulators. Writes land regardless of en; the accumulator
  // uses the increment held before the write edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        inc_r[c]   <= '0;
        acc_r[c]   <= '0;
        shift_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (sync_clr)  acc_r[c] <= '0;
        else if (en)   acc_r[c] <= acc_r[c] + inc_r[c];
      end
      if (cfg_we && (int'(cfg_ch) < N_CH)) begin
        inc_r[cfg_ch]   <= cfg_inc;
        shift_r[cfg_ch] <= cfg_shift;
      end
    end
  end

`ifdef TONE_DITHER_EN
  localparam int FRAC_W = PHASE_W - HI_W;
  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dither;

  always_ff @(posedge clk) begin
    if (reset)   lfsr <= LFSR_SEED;
    else if (en) lfsr <= lfsr_next(lfsr);
  end

  // Align the LFSR to the top of the truncated fraction field.
  if (FRAC_W >= 16) begin : g_dith_hi
    assign dither = PHASE_W'(lfsr) << (FRAC_W - 16);
  end else begin : g_dith_lo
    assign dither = PHASE_W'(lfsr >> (16 - FRAC_W));
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      phase_top[c] = HI_W'((acc_r[c] + dither) >> FRAC_W);
    end
  end
`else
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      phase_top[c] = acc_r[c][PHASE_W-1 -: HI_W];
    end
  end
`endif

  // Odd quadrants walk the quarter wave backwards: 2^LUT_AW - a.
  always_comb begin
    addr_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (phase_top[c][LUT_AW])
        addr_c[c*AW +: AW] = (AW'(1) << LUT_AW) - AW'(phase_top[c][LUT_AW-1:0]);
      else
        addr_c[c*AW +: AW] = AW'(phase_top[c][LUT_AW-1:0]);
    end
  end

  // S2 and the quadrant delay that travels alongside the LUT read.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_s2 <= '0;
      v_s2    <= 1'b0;
      v_s3    <= 1'b0;
      v_s4    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        q_s2[c] <= QUAD_0;
        q_s3[c] <= QUAD_0;
      end
    end else begin
      if (sync_clr) begin
        v_s2 <= 1'b0;
        v_s3 <= 1'b0;
        v_s4 <= 1'b0;
      end else if (en) begin
        v_s2 <= 1'b1;
        v_s3 <= v_s2;
        v_s4 <= v_s3;
      end
      if (en) begin
        addr_s2 <= addr_c;
        for (int c = 0; c < N_CH; c++) begin
          q_s2[c] <= quadrant_t'(phase_top[c][HI_W-1 -: 2]);
          q_s3[c] <= q_s2[c];
        end
      end
    end
  end

  sine_quarter_lut #(
    .N_RD   (N_CH),
    .LUT_AW (LUT_AW),
    .SIN_W  (SIN_W)
  ) u_lut (
    .clk  (clk),
    .en   (en),
    .addr (addr_s2),
    .data (lut_q)
  );

  // S3 tail: sign from quadrant, then attenuation.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      lut_s[c]   = lut_q[c*SIN_W +: SIN_W];
      tone_s3[c] = ((q_s3[c] == QUAD_2) || (q_s3[c] == QUAD_3)) ?
                   ((-lut_s[c]) >>> shift_r[c]) : (lut_s[c] >>> shift_r[c]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      sum_c = sum_c + SUM_W'(tone_s3[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   sum_s4 <= '0;
    else if (en) sum_s4 <= sum_c;
  end

  if (OUT_B_MODE == 1) begin : g_b_ch0
    logic signed [SUM_W-1:0] ch0_s4;
    always_ff @(posedge clk) begin
      if (reset)   ch0_s4 <= '0;
      else if (en) ch0_s4 <= SUM_W'(tone_s3[0]);
    end
    assign b_src = ch0_s4;
  end else begin : g_b_sum
    assign b_src = sum_s4;
  end

  always_comb begin
    sat_a   = saturate(32'(sum_s4), DAC_W);
    sat_b   = saturate(32'(b_src), DAC_W);
    clamp_a = (sat_a != 32'(sum_s4));
    clamp_b = (sat_b != 32'(b_src));
  end

  // S5: outputs only move on valid samples so a flush leaves them parked.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_a     <= MID;
      dac_b     <= MID;
      dac_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (sync_clr) begin
        dac_valid <= 1'b0;
      end else if (en) begin
        dac_valid <= v_s4;
        if (v_s4) begin
          dac_a <= DAC_W'(to_offset_binary(sat_a, DAC_W));
          dac_b <= DAC_W'(to_offset_binary(sat_b, DAC_W));
        end
      end
      // Set wins over a simultaneous clear.
      if (en && !sync_clr && v_s4 && (clamp_a || clamp_b)) ovf <= 1'b1;
      else if (ovf_clr)                                     ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_tone_dac_driver.sv
// Bench for multi_tone_dac_driver: two instances share stimulus, one with
// port B following the sum and one with port B following channel 0 alone.
// Directed table of per-cycle inputs and hand-computed outputs, then
// hand-written sequences for reset mid-operation and the fill latency.
module tb_multi_tone_dac_driver;

  logic        clk = 1'b0;
  logic        reset, en, sync_clr, cfg_we, ovf_clr;
  logic [0:0]  cfg_ch;
  logic [31:0] cfg_inc;
  logic [2:0]  cfg_shift;
  logic [13:0] a0, b0, a1, b1;
  logic        v0, v1, o0, o1;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  multi_tone_dac_driver #(.OUT_B_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_shift(cfg_shift), .ovf_clr(ovf_clr),
    .dac_a(a0), .dac_b(b0), .dac_valid(v0), .ovf(o0)
  );

  multi_tone_dac_driver #(.OUT_B_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_shift(cfg_shift), .ovf_clr(ovf_clr),
    .dac_a(a1), .dac_b(b1), .dac_valid(v1), .ovf(o1)
  );

  typedef struct {
    logic        en, clr, we;
    logic [0:0]  ch;
    logic [31:0] inc;
    logic [2:0]  sh;
    logic        oclr;
    logic        v;
    logic [13:0] a;    // dut0 a/b and dut1 a (summed path)
    logic [13:0] b1;   // dut1 b (channel 0 alone)
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en_i, clr_i, we_i, input logic [0:0] ch_i,
                              input logic [31:0] inc_i, input logic [2:0] sh_i,
                              input logic oclr_i, v_i, input logic [13:0] a_i, b1_i,
                              input logic ovf_i);
    vec_t r;
    r.en = en_i; r.clr = clr_i; r.we = we_i; r.ch = ch_i; r.inc = inc_i;
    r.sh = sh_i; r.oclr = oclr_i; r.v = v_i; r.a = a_i; r.b1 = b1_i; r.ovf = ovf_i;
    vecs.push_back(r);
  endfunction

  // Plain en/hold row: no config, no clears.
  function automatic void run(input logic en_i, v_i, input logic [13:0] a_i, b1_i,
                              input logic ovf_i);
    add(en_i, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, v_i, a_i, b1_i, ovf_i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; sync_clr = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0;
    cfg_inc = 32'h0; cfg_shift = 3'd0; ovf_clr = 1'b0;
  endtask

  initial begin
    int n;
    logic got;
    logic [13:0] ea;

    // Reset state and hold with en low.
    run(0, 0, 14'h2000, 14'h2000, 0);
    run(0, 0, 14'h2000, 14'h2000, 0);
    // Single tone at quarter-cycle steps on channel 0.
    add(0, 0, 1, 1'b0, 32'h4000_0000, 3'd0, 0, 0, 14'h2000, 14'h2000, 0);
    for (int i = 0; i < 3; i++) run(1, 0, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h3FFF, 14'h3FFF, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h0001, 14'h0001, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h3FFF, 14'h3FFF, 0);
    // en low: everything holds, then resumes in sequence.
    run(0, 1, 14'h3FFF, 14'h3FFF, 0);
    run(0, 1, 14'h3FFF, 14'h3FFF, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h0001, 14'h0001, 0);
    // sync_clr together with a channel 1 write: both in-phase, sum clamps.
    add(1, 1, 1, 1'b1, 32'h4000_0000, 3'd0, 0, 0, 14'h0001, 14'h0001, 0);
    for (int i = 0; i < 3; i++) run(1, 0, 14'h0001, 14'h0001, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h3FFF, 14'h3FFF, 1);
    run(1, 1, 14'h2000, 14'h2000, 1);
    run(1, 1, 14'h0000, 14'h0001, 1);
    run(1, 1, 14'h2000, 14'h2000, 1);
    // ovf_clr coinciding with a clamp: set wins. Then a clean clear.
    add(1, 0, 0, 1'b0, 32'h0, 3'd0, 1, 1, 14'h3FFF, 14'h3FFF, 1);
    add(0, 0, 0, 1'b0, 32'h0, 3'd0, 1, 1, 14'h3FFF, 14'h3FFF, 0);
    // Both channels attenuated by 1: peak 8190, trough -8192, no clamp.
    add(0, 0, 1, 1'b0, 32'h4000_0000, 3'd1, 0, 1, 14'h3FFF, 14'h3FFF, 0);
    add(0, 0, 1, 1'b1, 32'h4000_0000, 3'd1, 0, 1, 14'h3FFF, 14'h3FFF, 0);
    add(0, 1, 0, 1'b0, 32'h0, 3'd0, 0, 0, 14'h3FFF, 14'h3FFF, 0);
    for (int i = 0; i < 3; i++) run(1, 0, 14'h3FFF, 14'h3FFF, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h3FFE, 14'h2FFF, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h0000, 14'h1000, 0);
    // Two different tones: B stays the single channel 0 tone.
    add(0, 0, 1, 1'b0, 32'h4000_0000, 3'd0, 0, 1, 14'h0000, 14'h1000, 0);
    add(0, 0, 1, 1'b1, 32'h2000_0000, 3'd0, 0, 1, 14'h0000, 14'h1000, 0);
    add(0, 1, 0, 1'b0, 32'h0, 3'd0, 0, 0, 14'h0000, 14'h1000, 0);
    for (int i = 0; i < 3; i++) run(1, 0, 14'h0000, 14'h1000, 0);
    run(1, 1, 14'h2000, 14'h2000, 0);
    run(1, 1, 14'h3FFF, 14'h3FFF, 1);
    run(1, 1, 14'h3FFF, 14'h2000, 1);
    run(1, 1, 14'h16A1, 14'h0001, 1);
    run(1, 1, 14'h2000, 14'h2000, 1);
    run(1, 1, 14'h295F, 14'h3FFF, 1);
    run(1, 1, 14'h0001, 14'h2000, 1);
    run(1, 1, 14'h0000, 14'h0001, 1);

    // Clock/reset.
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; sync_clr = vecs[i].clr; cfg_we = vecs[i].we;
      cfg_ch = vecs[i].ch; cfg_inc = vecs[i].inc; cfg_shift = vecs[i].sh;
      ovf_clr = vecs[i].oclr;
      exp_q.push_back(vecs[i].a);
      step();
      ea = exp_q.pop_front();
      check($sformatf("row%0d dut0 dac_valid", i), 32'(v0), 32'(vecs[i].v));
      check($sformatf("row%0d dut0 dac_a", i),     32'(a0), 32'(ea));
      check($sformatf("row%0d dut0 dac_b", i),     32'(b0), 32'(ea));
      check($sformatf("row%0d dut0 ovf", i),       32'(o0), 32'(vecs[i].ovf));
      check($sformatf("row%0d dut1 dac_a", i),     32'(a1), 32'(ea));
      check($sformatf("row%0d dut1 dac_b", i),     32'(b1), 32'(vecs[i].b1));
      check($sformatf("row%0d dut1 dac_valid", i), 32'(v1), 32'(vecs[i].v));
    end

    // Reset mid-operation (ovf set, valid high) returns to reset state.
    idle_inputs();
    en = 1'b1;
    reset = 1'b1;
    step();
    check("midreset dac_a", 32'(a0), 32'h2000);
    check("midreset dac_b", 32'(b1), 32'h2000);
    check("midreset dac_valid", 32'(v0), 32'h0);
    check("midreset ovf", 32'(o0), 32'h0);
    check("midreset dut1 ovf", 32'(o1), 32'h0);
    reset = 1'b0;

    // Fill latency after reset with bounded wait; increments were cleared,
    // so the output sits at mid-scale.
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      n++;
      if (v0) got = 1'b1;
    end
    check("fill latency en-cycles", 32'(n), 32'd4);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("post-reset inc cleared %0d", k), 32'(a0), 32'h2000);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
